// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter_pkg
//  Brief    : Shared constants, requester IDs and FSM encoding for the
//             two-requester memory arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

  localparam int ADDR_BITS_DEF   = 28;
  localparam int DATA_BITS_DEF   = 128;
  localparam int ROUTE_DEPTH_DEF = 4;

  // Requester indices into the packed per-requester buses
  localparam logic ICACHE = 1'b0;
  localparam logic DCACHE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADDR  = 2'd1,
    ST_WDATA = 2'd2
  } arb_state_e;

  // Occupancy counter width: must represent 0..depth inclusive
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_route_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : mem_route_fifo
//  Brief    : 1-bit wide route FIFO recording which requester owns each
//             outstanding read, so responses are steered in issue order.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_route_fifo
  import mem_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push_i,
  input  logic                   push_data_i,
  input  logic                   pop_i,
  output logic                   head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = cnt_width(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DEPTH-1:0] slot_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = slot_q[rd_ptr_q];

  // A push into a full FIFO is only legal when a pop frees a slot that cycle
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Storage, wrapping pointers and occupancy count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        slot_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q         <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Brief    : Round-robin arbiter between icache (0) and dcache (1) onto a
//             single memory port; in-order read responses routed back via a
//             route FIFO.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_BITS   = ADDR_BITS_DEF,
  parameter int DATA_BITS   = DATA_BITS_DEF,
  parameter int ROUTE_DEPTH = ROUTE_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [1:0]               rq_req_valid,
  output logic [1:0]               rq_req_ready,
  input  logic [2*ADDR_BITS-1:0]   rq_req_addr,
  input  logic [1:0]               rq_req_rw,
  input  logic [1:0]               rq_data_valid,
  output logic [1:0]               rq_data_ready,
  input  logic [2*DATA_BITS-1:0]   rq_data_bits,
  input  logic [2*DATA_BITS/8-1:0] rq_data_mask,
  output logic [1:0]               rq_resp_valid,
  output logic [DATA_BITS-1:0]     rq_resp_data,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic [ADDR_BITS-1:0]     mem_req_addr,
  output logic                     mem_req_rw,
  output logic                     mem_req_data_valid,
  input  logic                     mem_req_data_ready,
  output logic [DATA_BITS-1:0]     mem_req_data_bits,
  output logic [DATA_BITS/8-1:0]   mem_req_data_mask,
  input  logic                     mem_resp_valid,
  input  logic [DATA_BITS-1:0]     mem_resp_data
);

  localparam int MASK_BITS = DATA_BITS / 8;
  localparam int CNT_W     = cnt_width(ROUTE_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(ROUTE_DEPTH);

  arb_state_e       state_q, state_d;
  logic             g_q, g_d;              // granted requester
  logic             last_q, last_d;        // requester granted most recently
  logic             rw_q, rw_d;            // direction of the granted transaction
  logic             addr_done_q, addr_done_d;
  logic             data_done_q, data_done_d;

  logic [1:0]       elig;
  logic             winner;
  logic             room;
  logic             addr_hs;
  logic             data_hs;
  logic             push_req;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  // A read needs a free route slot; writes never produce a response
  assign room   = (fifo_count < DEPTH_CNT);
  assign elig   = rq_req_valid & (rq_req_rw | {2{room}});
  assign winner = (&elig) ? ~last_q : elig[DCACHE];

  // Address/data payload simply follows the held grant
  assign mem_req_addr      = g_q ? rq_req_addr[2*ADDR_BITS-1:ADDR_BITS] : rq_req_addr[ADDR_BITS-1:0];
  assign mem_req_rw        = rq_req_rw[g_q];
  assign mem_req_data_bits = g_q ? rq_data_bits[2*DATA_BITS-1:DATA_BITS] : rq_data_bits[DATA_BITS-1:0];
  assign mem_req_data_mask = g_q ? rq_data_mask[2*MASK_BITS-1:MASK_BITS] : rq_data_mask[MASK_BITS-1:0];

  // In-order response steering; a response with nothing outstanding is dropped
  assign fifo_pop             = mem_resp_valid && !fifo_empty;
  assign rq_resp_valid[ICACHE] = fifo_pop && (fifo_head == ICACHE);
  assign rq_resp_valid[DCACHE] = fifo_pop && (fifo_head == DCACHE);
  assign rq_resp_data         = mem_resp_data;
  assign fifo_push            = push_req && !fifo_full;

  mem_route_fifo #(
    .DEPTH (ROUTE_DEPTH)
  ) u_route_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (fifo_push),
    .push_data_i (g_q),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  // FSM and grant registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      g_q         <= ICACHE;
      last_q      <= DCACHE;
      rw_q        <= 1'b0;
      addr_done_q <= 1'b0;
      data_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      g_q         <= g_d;
      last_q      <= last_d;
      rw_q        <= rw_d;
      addr_done_q <= addr_done_d;
      data_done_q <= data_done_d;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    state_d            = state_q;
    g_d                = g_q;
    last_d             = last_q;
    rw_d               = rw_q;
    addr_done_d        = addr_done_q;
    data_done_d        = data_done_q;
    push_req           = 1'b0;
    addr_hs            = 1'b0;
    data_hs            = 1'b0;
    mem_req_valid      = 1'b0;
    mem_req_data_valid = 1'b0;
    rq_req_ready       = '0;
    rq_data_ready      = '0;

    case (state_q)
      ST_IDLE: begin
        if (|elig) begin
          g_d         = winner;
          last_d      = winner;
          rw_d        = rq_req_rw[winner];
          addr_done_d = 1'b0;
          data_done_d = 1'b0;
          state_d     = ST_ADDR;
        end
      end

      ST_ADDR: begin
        mem_req_valid      = rq_req_valid[g_q] && !addr_done_q;
        rq_req_ready[g_q]  = mem_req_ready && !addr_done_q;
        addr_hs            = mem_req_valid && mem_req_ready;
        if (rw_q) begin
          mem_req_data_valid = rq_data_valid[g_q] && !data_done_q;
          rq_data_ready[g_q] = mem_req_data_ready && !data_done_q;
          data_hs            = mem_req_data_valid && mem_req_data_ready;
          addr_done_d        = addr_done_q || addr_hs;
          data_done_d        = data_done_q || data_hs;
          if (addr_done_d && data_done_d) begin
            state_d = ST_IDLE;
          end else if (addr_done_d) begin
            state_d = ST_WDATA;
          end
        end else if (addr_hs) begin
          push_req    = 1'b1;
          addr_done_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      ST_WDATA: begin
        mem_req_data_valid = rq_data_valid[g_q] && !data_done_q;
        rq_data_ready[g_q] = mem_req_data_ready && !data_done_q;
        data_hs            = mem_req_data_valid && mem_req_data_ready;
        data_done_d        = data_done_q || data_hs;
        if (data_done_d) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule
`default_nettype wire
